// File: rtl/toy_multi_controller.sv
// Multi-cycle control FSM for a 16-bit toy CPU: sequences fetch, decode, execute,
// memory and write-back, and decodes the datapath strobes from state and instruction.
module toy_multi_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        mem_ready,
    input  logic        z,
    input  logic        c,
    output logic [2:0]  alu_op,
    output logic        alu_src_sel,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic        pc_src_sel,
    output logic        wb_sel,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    state_e r_state;
    state_e w_state_next;
    logic   r_z_flag;
    logic   r_c_flag;

    logic [3:0] w_opcode;
    logic       w_is_rtype;
    logic       w_is_addi;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_is_jz;
    logic       w_is_jc;
    logic       w_is_jmp;
    logic       w_is_halt;
    logic       w_is_illegal;
    logic       w_br_taken;
    logic       w_flag_we;
    logic       w_unused;

    // Immediate and register fields feed the datapath, not this controller.
    assign w_unused = ^instr[11:0];

    assign w_opcode     = instr[15:12];
    // 0000, 0001, 0100..0111; 0010/0011 are holes in the R-type range.
    assign w_is_rtype   = !w_opcode[3] && (w_opcode[2:1] != 2'b01);
    assign w_is_addi    = (w_opcode == 4'b1000);
    assign w_is_load    = (w_opcode == 4'b1001);
    assign w_is_store   = (w_opcode == 4'b1010);
    assign w_is_jz      = (w_opcode == 4'b1011);
    assign w_is_jc      = (w_opcode == 4'b1100);
    assign w_is_jmp     = (w_opcode == 4'b1101);
    assign w_is_halt    = (w_opcode == 4'b1111);
    assign w_is_illegal = !(w_is_rtype || w_is_addi || w_is_load || w_is_store ||
                            w_is_jz || w_is_jc || w_is_jmp || w_is_halt);

    // Branches test the flags left by an earlier instruction, never the live z/c.
    assign w_br_taken = w_is_jmp || (w_is_jz && r_z_flag) || (w_is_jc && r_c_flag);
    assign w_flag_we  = (r_state == StExec) && (w_is_rtype || w_is_addi);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StFetch;
            r_z_flag <= 1'b0;
            r_c_flag <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_flag_we) begin
                r_z_flag <= z;
                r_c_flag <= c;
            end
        end
    end

    always_comb begin
        w_state_next = StFetch;
        alu_op       = 3'b000;
        alu_src_sel  = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        reg_we       = 1'b0;
        pc_src_sel   = 1'b0;
        wb_sel       = 1'b0;
        halted       = 1'b0;
        illegal      = 1'b0;

        case (r_state)
            StFetch: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_we        = 1'b1;
                    pc_we        = 1'b1;
                    w_state_next = StDecode;
                end else begin
                    w_state_next = StFetch;
                end
            end
            StDecode: begin
                if (w_is_halt) begin
                    w_state_next = StHalt;
                end else if (w_is_illegal) begin
                    illegal      = 1'b1;
                    w_state_next = StFetch;
                end else begin
                    w_state_next = StExec;
                end
            end
            StExec: begin
                if (w_is_rtype) begin
                    alu_op       = instr[14:12];
                    w_state_next = StWb;
                end else if (w_is_addi) begin
                    alu_src_sel  = 1'b1;
                    w_state_next = StWb;
                end else if (w_is_load || w_is_store) begin
                    alu_src_sel  = 1'b1;
                    w_state_next = StMem;
                end else begin
                    pc_we        = w_br_taken;
                    pc_src_sel   = w_br_taken;
                    w_state_next = StFetch;
                end
            end
            StMem: begin
                mem_rd = w_is_load;
                mem_wr = w_is_store;
                if (mem_ready) begin
                    w_state_next = w_is_load ? StWb : StFetch;
                end else begin
                    w_state_next = StMem;
                end
            end
            StWb: begin
                reg_we       = 1'b1;
                wb_sel       = w_is_load;
                w_state_next = StFetch;
            end
            StHalt: begin
                halted       = 1'b1;
                w_state_next = StHalt;
            end
            default: w_state_next = StFetch;
        endcase

        // Reset wins over everything so an abandoned instruction cannot write.
        if (rst) begin
            alu_op      = 3'b000;
            alu_src_sel = 1'b0;
            mem_rd      = 1'b0;
            mem_wr      = 1'b0;
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            reg_we      = 1'b0;
            pc_src_sel  = 1'b0;
            wb_sel      = 1'b0;
            halted      = 1'b0;
            illegal     = 1'b0;
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_toy_multi_controller.sv
// Scoreboard bench for toy_multi_controller: directed instruction sequences push the
// expected per-cycle control word; a negedge monitor pops and compares.
module tb_toy_multi_controller;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic        mem_ready;
    logic        z;
    logic        c;
    logic [2:0]  alu_op;
    logic        alu_src_sel;
    logic        mem_rd;
    logic        mem_wr;
    logic        ir_we;
    logic        pc_we;
    logic        reg_we;
    logic        pc_src_sel;
    logic        wb_sel;
    logic [2:0]  state;
    logic        halted;
    logic        illegal;

    toy_multi_controller dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .mem_ready   (mem_ready),
        .z           (z),
        .c           (c),
        .alu_op      (alu_op),
        .alu_src_sel (alu_src_sel),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .reg_we      (reg_we),
        .pc_src_sel  (pc_src_sel),
        .wb_sel      (wb_sel),
        .state       (state),
        .halted      (halted),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word layout: {state, alu_op, asrc, rd, wr, ir, pc, reg, psrc, wb, halted, illegal}
    localparam logic [9:0] ASRC = 10'h200;
    localparam logic [9:0] RD   = 10'h100;
    localparam logic [9:0] WR   = 10'h080;
    localparam logic [9:0] IR   = 10'h040;
    localparam logic [9:0] PCW  = 10'h020;
    localparam logic [9:0] RW   = 10'h010;
    localparam logic [9:0] PSRC = 10'h008;
    localparam logic [9:0] WB   = 10'h004;
    localparam logic [9:0] HLT  = 10'h002;
    localparam logic [9:0] ILL  = 10'h001;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_vec;
    int  n_err;

    logic [15:0] w_obs;
    assign w_obs = {state, alu_op, alu_src_sel, mem_rd, mem_wr, ir_we, pc_we, reg_we,
                    pc_src_sel, wb_sel, halted, illegal};

    function automatic logic [15:0] ex(input logic [2:0] st, input logic [2:0] aop,
                                       input logic [9:0] f);
        return {st, aop, f};
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            n_vec++;
            if (w_obs !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h (t=%0t)", e.name, w_obs, e.exp, $time);
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic [15:0] ins,
                        input logic mr, input logic zi, input logic ci,
                        input logic [15:0] exp);
        sb_t e;
        rst       = r;
        instr     = ins;
        mem_ready = mr;
        z         = zi;
        c         = ci;
        e.name    = nm;
        e.exp     = exp;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string nm, input logic [15:0] ins);
        step({nm, "_fetch"}, 1'b0, ins, 1'b1, 1'b0, 1'b0, ex(3'd0, 3'd0, RD | IR | PCW));
        step({nm, "_decode"}, 1'b0, ins, 1'b1, 1'b0, 1'b0, ex(3'd1, 3'd0, 10'h000));
    endtask

    task automatic rtype(input string nm, input logic [15:0] ins, input logic zi,
                         input logic ci, input logic [2:0] aop);
        fetch_decode(nm, ins);
        step({nm, "_exec"}, 1'b0, ins, 1'b1, zi, ci, ex(3'd2, aop, 10'h000));
        step({nm, "_wb"}, 1'b0, ins, 1'b1, 1'b0, 1'b0, ex(3'd4, 3'd0, RW));
    endtask

    task automatic addi(input string nm, input logic [15:0] ins, input logic zi,
                        input logic ci);
        fetch_decode(nm, ins);
        step({nm, "_exec"}, 1'b0, ins, 1'b1, zi, ci, ex(3'd2, 3'd0, ASRC));
        step({nm, "_wb"}, 1'b0, ins, 1'b1, 1'b0, 1'b0, ex(3'd4, 3'd0, RW));
    endtask

    task automatic branch(input string nm, input logic [15:0] ins, input logic zi,
                          input logic ci, input logic taken);
        fetch_decode(nm, ins);
        step({nm, "_exec"}, 1'b0, ins, 1'b0, zi, ci,
             ex(3'd2, 3'd0, taken ? (PCW | PSRC) : 10'h000));
    endtask

    task automatic load(input string nm, input logic [15:0] ins, input int nwait);
        fetch_decode(nm, ins);
        step({nm, "_exec"}, 1'b0, ins, 1'b1, 1'b1, 1'b1, ex(3'd2, 3'd0, ASRC));
        for (int i = 0; i < nwait; i++)
            step({nm, "_mem_wait"}, 1'b0, ins, 1'b0, 1'b0, 1'b0, ex(3'd3, 3'd0, RD));
        step({nm, "_mem_done"}, 1'b0, ins, 1'b1, 1'b0, 1'b0, ex(3'd3, 3'd0, RD));
        step({nm, "_wb"}, 1'b0, ins, 1'b0, 1'b0, 1'b0, ex(3'd4, 3'd0, RW | WB));
    endtask

    task automatic store(input string nm, input logic [15:0] ins, input logic zi,
                         input logic ci);
        fetch_decode(nm, ins);
        step({nm, "_exec"}, 1'b0, ins, 1'b1, zi, ci, ex(3'd2, 3'd0, ASRC));
        step({nm, "_mem"}, 1'b0, ins, 1'b1, 1'b0, 1'b0, ex(3'd3, 3'd0, WR));
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        instr     = 16'hF000;
        mem_ready = 1'b1;
        z         = 1'b0;
        c         = 1'b0;
        @(posedge clk);
        #1;
        step("rst_hold0", 1'b1, 16'hF000, 1'b1, 1'b1, 1'b1, ex(3'd0, 3'd0, 10'h000));
        step("rst_hold1", 1'b1, 16'h9000, 1'b1, 1'b1, 1'b1, ex(3'd0, 3'd0, 10'h000));

        rtype("add", 16'h0123, 1'b1, 1'b0, 3'd0);
        rtype("sub", 16'h1456, 1'b1, 1'b0, 3'd1);
        branch("jz_after_sub", 16'hB000, 1'b0, 1'b1, 1'b1);
        rtype("xor", 16'h5789, 1'b0, 1'b1, 3'd5);
        branch("jz_after_xor", 16'hB000, 1'b1, 1'b0, 1'b0);
        branch("jc_after_xor", 16'hC000, 1'b0, 1'b0, 1'b1);
        rtype("and", 16'h7000, 1'b0, 1'b0, 3'd7);

        step("fetch_wait", 1'b0, 16'h9005, 1'b0, 1'b0, 1'b0, ex(3'd0, 3'd0, RD));
        load("load", 16'h9005, 3);
        branch("jz_after_load", 16'hB000, 1'b1, 1'b1, 1'b0);
        addi("addi", 16'h8FFF, 1'b1, 1'b1);
        branch("jc_after_addi", 16'hC000, 1'b0, 1'b0, 1'b1);
        store("store", 16'hA010, 1'b0, 1'b0);
        branch("jz_after_store", 16'hB000, 1'b0, 1'b0, 1'b1);
        branch("jmp", 16'hD000, 1'b0, 1'b0, 1'b1);

        step("ill2_fetch", 1'b0, 16'h2000, 1'b1, 1'b0, 1'b0, ex(3'd0, 3'd0, RD | IR | PCW));
        step("ill2_decode", 1'b0, 16'h2000, 1'b1, 1'b0, 1'b0, ex(3'd1, 3'd0, ILL));
        step("illE_fetch", 1'b0, 16'hE000, 1'b1, 1'b0, 1'b0, ex(3'd0, 3'd0, RD | IR | PCW));
        step("illE_decode", 1'b0, 16'hE000, 1'b1, 1'b0, 1'b0, ex(3'd1, 3'd0, ILL));

        // Abandon a STORE in its MEM wait while both flags are set.
        fetch_decode("st_rst", 16'hA020);
        step("st_rst_exec", 1'b0, 16'hA020, 1'b1, 1'b1, 1'b1, ex(3'd2, 3'd0, ASRC));
        step("st_rst_wait", 1'b0, 16'hA020, 1'b0, 1'b0, 1'b0, ex(3'd3, 3'd0, WR));
        step("st_rst_assert", 1'b1, 16'hA020, 1'b1, 1'b0, 1'b0, ex(3'd3, 3'd0, 10'h000));
        step("post_rst_fetch_wait", 1'b0, 16'hB000, 1'b0, 1'b0, 1'b0, ex(3'd0, 3'd0, RD));
        step("post_rst_fetch", 1'b0, 16'hB000, 1'b1, 1'b0, 1'b0, ex(3'd0, 3'd0, RD | IR | PCW));
        step("post_rst_decode", 1'b0, 16'hB000, 1'b1, 1'b0, 1'b0, ex(3'd1, 3'd0, 10'h000));
        step("post_rst_jz_exec", 1'b0, 16'hB000, 1'b1, 1'b1, 1'b1, ex(3'd2, 3'd0, 10'h000));
        branch("post_rst_jc", 16'hC000, 1'b1, 1'b1, 1'b0);

        fetch_decode("halt", 16'hF000);
        for (int i = 0; i < 10; i++)
            step("halt_idle", 1'b0, 16'h0000, i[0], i[1], i[2], ex(3'd5, 3'd0, HLT));
        step("halt_rst", 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, ex(3'd5, 3'd0, 10'h000));
        step("halt_rst_fetch", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, ex(3'd0, 3'd0, RD | IR | PCW));

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/toy_multi_controller.md
TOY_MULTI_CONTROLLER -- requirements
Module: toy_multi_controller

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising-edge; all state updates on this edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-003 SHALL have: instr  in  16  instruction register contents; opcode = instr[15:12].
REQ-004 SHALL have: mem_ready  in  1  memory handshake; completes the current mem_rd/mem_wr.
REQ-005 SHALL have: z, c  in  1 each  ALU zero/carry outputs, valid in EXEC.
REQ-006 SHALL have: alu_op  out  3  ALU operation select.
REQ-007 SHALL have: alu_src_sel  out  1  ALU B operand; 0 = register, 1 = sign-extended instr[7:0].
REQ-008 SHALL have: mem_rd, mem_wr  out  1 each  memory strobes.
REQ-009 SHALL have: ir_we, pc_we, reg_we  out  1 each  register write enables.
REQ-010 SHALL have: pc_src_sel  out  1  0 = PC+1, 1 = branch target.
REQ-011 SHALL have: wb_sel  out  1  0 = ALU result, 1 = memory data.
REQ-012 SHALL have: state  out  3  current FSM state; halted  out  1; illegal  out  1.

Function
REQ-013 SHALL use a one-hot-free FSM with encodings FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL go to FETCH on the next edge.
REQ-014 Opcodes SHALL be:
- 0000 ADD, 0001 SUB, 0100 SHL, 0101 XOR, 0110 OR, 0111 AND (R-type, alu_op = instr[14:12]);
- 1000 ADDI, 1001 LOAD, 1010 STORE, 1011 JZ, 1100 JC, 1101 JMP, 1111 HALT;
- all other opcodes illegal.
REQ-015 FETCH SHALL assert mem_rd and hold state until mem_ready=1; in the mem_ready cycle it SHALL assert ir_we and pc_we (pc_src_sel=0), then go to DECODE.
REQ-016 DECODE SHALL assert no strobes.
- HALT opcode goes to HALT.
- Illegal opcode pulses illegal for one cycle and goes to FETCH.
- All other opcodes go to EXEC.
REQ-017 EXEC, R-type: alu_op=instr[14:12], alu_src_sel=0; ADDI/LOAD/STORE: alu_op=000, alu_src_sel=1.
REQ-018 EXEC SHALL latch z and c into internal z_flag and c_flag for R-type and ADDI only; LOAD, STORE and branches SHALL leave the flags unchanged.
REQ-019 EXEC next state: R-type/ADDI go to WB; LOAD/STORE go to MEM; JZ/JC/JMP go to FETCH.
REQ-020 EXEC branches SHALL assert pc_we with pc_src_sel=1 when: JMP always; JZ when z_flag=1; JC when c_flag=1. The registered flag from a prior instruction is used, not the current z/c.
REQ-021 MEM SHALL hold mem_rd (LOAD) or mem_wr (STORE) until mem_ready=1; on mem_ready, LOAD goes to WB and STORE goes to FETCH.
REQ-022 WB SHALL assert reg_we for exactly one cycle, with wb_sel=1 for LOAD and 0 otherwise, then go to FETCH.
REQ-023 HALT SHALL hold halted=1, assert no strobes, and remain in HALT until rst.
REQ-024 Strobes SHALL decode combinationally from state and instr; no strobe SHALL be asserted outside the states listed above.
REQ-025 Latency with mem_ready tied high: R-type/ADDI 4 cycles, LOAD 5, STORE 4, branch 3. Each cycle of mem_ready=0 in FETCH or MEM adds one cycle.
REQ-026 mem_ready SHALL be ignored in DECODE, EXEC, WB and HALT.

Reset
REQ-027 While rst=1, on each edge: state SHALL be FETCH; z_flag=0, c_flag=0; halted=0; illegal=0.
REQ-028 While rst=1, all strobes (mem_rd, mem_wr, ir_we, pc_we, reg_we) SHALL be forced to 0.
REQ-029 While rst=1, alu_op, alu_src_sel, pc_src_sel and wb_sel SHALL be 0.
REQ-030 rst asserted mid-instruction, including during a MEM wait, SHALL abandon the instruction with no further writes.
REQ-031 The first FETCH mem_rd SHALL appear in the cycle after rst deasserts.

Verification
REQ-032 ADD with mem_ready=1, z=1, c=0 in EXEC: state 0,1,2,4,0; reg_we=1 in the WB cycle only; z_flag=1.
REQ-033 LOAD with mem_ready held low 3 cycles in MEM: mem_rd held 4 cycles in MEM; then WB with wb_sel=1; total 8 cycles.
REQ-034 JZ after SUB produced z=1: pc_we=1 and pc_src_sel=1 in EXEC. Same JZ after XOR produced z=0: pc_we=0 in EXEC; returns to FETCH.
REQ-035 Opcode 0010: illegal=1 for one cycle in DECODE; no reg_we or mem_wr; next state FETCH.
REQ-036 HALT then 10 idle cycles: halted=1 and state=5 throughout. Then rst=1 for 1 cycle: state=0, halted=0, mem_rd=1 in the next cycle.
REQ-037 rst asserted during STORE MEM wait: mem_wr=0 from the reset edge onward; state FETCH; flags 0.
